// File: rtl/unsigned_array_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier: AND-gate partial products summed by
// rows of half/full adders with ripple carry, product registered once on Y.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module unsigned_array_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Y
);

  logic [WIDTH-1:0][WIDTH-1:0] pp;
  logic [2*WIDTH-1:0]          p;
  logic [2*WIDTH-1:0]          y_d, y_q;

  genvar i, k;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_pp
      for (k = 0; k < WIDTH; k++) begin : g_bit
        assign pp[i][k] = A[k] & B[i];
      end
    end

    // Each row keeps WIDTH sum bits plus its carry-out in s; the next row adds
    // its partial products to s shifted down by one, and s[0] retires as P[i].
    for (i = 0; i < WIDTH; i++) begin : g_row
      logic [WIDTH:0] s;
      if (i == 0) begin : g_base
        assign s = {1'b0, pp[0]};
      end else begin : g_add
        for (k = 0; k < WIDTH; k++) begin : g_col
          logic co;
          if (k == 0) begin : g_ha
            half_adder u_ha (
              .a  (g_row[i-1].s[1]),
              .b  (pp[i][0]),
              .s  (s[0]),
              .co (co)
            );
          end else begin : g_fa
            full_adder u_fa (
              .a  (g_row[i-1].s[k+1]),
              .b  (pp[i][k]),
              .ci (g_col[k-1].co),
              .s  (s[k]),
              .co (co)
            );
          end
        end
        assign s[WIDTH] = g_col[WIDTH-1].co;
      end
      assign p[i] = s[0];
    end

    assign p[2*WIDTH-1:WIDTH] = g_row[WIDTH-1].s[WIDTH:1];
  endgenerate

  always_comb begin
    y_d = p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign Y = y_q;

endmodule

// File: tb/tb_unsigned_array_multiplier.sv
// Self-checking bench for unsigned_array_multiplier (WIDTH=4): directed table,
// back-to-back latency, exhaustive sweep with async reset pulse, random vectors.

module tb_unsigned_array_multiplier;
  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   A, B;
  logic [2*W-1:0] Y;

  int n_tests = 0;
  int n_fail  = 0;

  unsigned_array_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Y   (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [2*W-1:0] exp);
    n_tests++;
    if (Y !== exp) begin
      n_fail++;
      $display("FAIL %s: Y=%0d expected %0d", name, Y, exp);
    end
  endtask

  // Apply operands away from the edge, then sample just after the capturing edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input int a, input int b);
    return (2*W)'(a * b);
  endfunction

  initial begin
    vecs[0]  = '{"small_2x2",   4'd2,  4'd2,  8'd4};
    vecs[1]  = '{"small_3x3",   4'd3,  4'd3,  8'd9};
    vecs[2]  = '{"small_3x4",   4'd3,  4'd4,  8'd12};
    vecs[3]  = '{"small_3x5",   4'd3,  4'd5,  8'd15};
    vecs[4]  = '{"id_0x0",      4'd0,  4'd0,  8'd0};
    vecs[5]  = '{"id_1x1",      4'd1,  4'd1,  8'd1};
    vecs[6]  = '{"id_0x15",     4'd0,  4'd15, 8'd0};
    vecs[7]  = '{"id_1x13",     4'd1,  4'd13, 8'd13};
    vecs[8]  = '{"max_15x15",   4'd15, 4'd15, 8'hE1};
    vecs[9]  = '{"max_15x1",    4'd15, 4'd1,  8'd15};
    vecs[10] = '{"pow_8x8",     4'd8,  4'd8,  8'd64};
    vecs[11] = '{"mix_12x10",   4'd12, 4'd10, 8'd120};

    // Reset asserted between edges must clear Y at once and hold it.
    rst = 1'b0;
    A   = 4'd7;
    B   = 4'd9;
    #2 rst = 1'b1;
    #1 chk("reset_async", '0);
    @(posedge clk); #1 chk("reset_hold0", '0);
    @(posedge clk); #1 chk("reset_hold1", '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 chk("reset_release", 8'd63);

    foreach (vecs[v]) begin
      apply(vecs[v].a, vecs[v].b);
      chk(vecs[v].name, vecs[v].y);
    end

    // Back-to-back: each product shows exactly one edge after its operands.
    apply(4'd2, 4'd2);   chk("b2b_0", 8'd4);
    apply(4'd3, 4'd5);   chk("b2b_1", 8'd15);
    apply(4'd15, 4'd15); chk("b2b_2", 8'd225);

    // Inputs changing between edges must not disturb Y.
    @(negedge clk);
    A = 4'd6; B = 4'd7;
    #2 chk("hold_between_edges", 8'd225);
    @(posedge clk); #1 chk("hold_then_load", 8'd42);

    // Exhaustive sweep with an asynchronous reset pulse mid-way.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply(W'(a), W'(b));
        chk("exhaustive", ref_mul(a, b));
        if (a == 8 && b == 3) begin
          #2 rst = 1'b1;
          #1 chk("midrun_reset", '0);
          #1 rst = 1'b0;
          #1 chk("midrun_no_stale", '0);
        end
      end
    end

    // Randomized operands against plain integer multiplication.
    for (int n = 0; n < 200; n++) begin
      int ra, rb;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      apply(W'(ra), W'(rb));
      chk("random", ref_mul(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
